// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] definitions: lane/state types, rate constants and
// string-index helpers (string lane i = 5y + x).
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;

    // Rate portion of the state, in lanes, for the standard FIPS 202 instances
    localparam int RATE_SHA3_224 = 18;
    localparam int RATE_SHA3_256 = 17;
    localparam int RATE_SHA3_384 = 13;
    localparam int RATE_SHA3_512 = 9;
    localparam int RATE_SHAKE128 = 21;
    localparam int RATE_SHAKE256 = 17;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [0:4][0:4]  state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    function automatic logic [2:0] lane_x(input logic [4:0] i);
        return 3'(i % 5'd5);
    endfunction

    function automatic logic [2:0] lane_y(input logic [4:0] i);
        return 3'(i / 5'd5);
    endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Combinational 25:1 lane mux: picks A[i mod 5][i div 5] for string lane i.
// Indices outside 0..24 return zero.
module keccak_lane_select
    import keccak_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] idx,
    output lane_t      lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (idx == 5'(i)) begin
                lane = state[lane_x(5'(i))][lane_y(5'(i))];
            end
        end
    end

endmodule

// File: rtl/keccak_state_serializer.sv
// Captures a full Keccak-f[1600] state and streams its first num_lanes lanes
// in string order (i = 5y + x) over a valid/ready lane interface.
module keccak_state_serializer #(
    parameter int LANE_W    = 64,
    parameter int MAX_LANES = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [0:4][0:4][LANE_W-1:0]   state_in,
    input  logic [4:0]                    num_lanes,
    output logic [LANE_W-1:0]             lane_out,
    output logic [4:0]                    lane_idx,
    output logic                          lane_valid,
    input  logic                          lane_ready,
    output logic                          lane_last,
    output logic                          done
);

    import keccak_pkg::*;

    ser_state_e state_q;
    logic [4:0] cnt_q;
    logic [4:0] last_q;
    state_t     lanes_q;
    logic       done_q;
    logic [4:0] eff_lanes;
    lane_t      lane_sel;

    // Zero or out-of-range counts fall back to emitting the whole state
    always_comb begin
        eff_lanes = num_lanes;
        if (num_lanes == 5'd0 || num_lanes > 5'(MAX_LANES)) begin
            eff_lanes = 5'(MAX_LANES);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            lanes_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        lanes_q <= state_in;
                        last_q  <= eff_lanes - 5'd1;
                        cnt_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (lane_ready) begin
                        if (cnt_q == last_q) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    keccak_lane_select u_lane_select (
        .state (lanes_q),
        .idx   (cnt_q),
        .lane  (lane_sel)
    );

    // Every output is a function of registered state only; lane_ready never
    // reaches an output combinationally.
    assign lane_out   = lane_sel;
    assign lane_idx   = cnt_q;
    assign load_ready = (state_q == ST_IDLE);
    assign lane_valid = (state_q == ST_SEND);
    assign lane_last  = (state_q == ST_SEND) && (cnt_q == last_q);
    assign done       = done_q;

endmodule
